// File: rtl/add_three_arb_pkg.sv
// Shared types and constants for the three-operand adder arbiter.
package add_three_arb_pkg;

    localparam int DEF_BW   = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // The low bits of the exact sum are the wrapped result; the result has
    // overflowed when the two top bits of the exact sum disagree.
    function automatic logic sum_ovf(input logic [1:0] top2);
        return top2[1] ^ top2[0];
    endfunction

endpackage

// File: rtl/add_three_arb_if.sv
// Requester and result handshake bundle for add_three_arb.
interface add_three_arb_if
    import add_three_arb_pkg::*;
#(
    parameter int BW   = DEF_BW,
    parameter int NREQ = DEF_NREQ
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][BW-1:0] req_a;
    logic [NREQ-1:0][BW-1:0] req_b;
    logic [NREQ-1:0][BW-1:0] req_c;
    logic                    res_valid;
    logic                    res_ready;
    logic [BW:0]             res_sum;
    logic [IDW-1:0]          res_id;
    logic                    res_ovf;

    modport master (
        output req_valid, req_a, req_b, req_c, res_ready,
        input  req_ready, res_valid, res_sum, res_id, res_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, res_ready,
        output req_ready, res_valid, res_sum, res_id, res_ovf
    );
endinterface

// File: rtl/add_three_core.sv
// Combinational signed a+b+c with wrapped BW+1 sum and overflow flag.
module add_three_core
    import add_three_arb_pkg::*;
#(
    parameter int BW = DEF_BW
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [BW-1:0] c,
    output logic [BW:0]   sum,
    output logic          ovf
);
    logic [BW+1:0] s;

    // Two guard bits make the three-way sum exact for any operands.
    assign s   = {{2{a[BW-1]}}, a} + {{2{b[BW-1]}}, b} + {{2{c[BW-1]}}, c};
    assign sum = s[BW:0];
    assign ovf = sum_ovf(s[BW+1:BW]);
endmodule

// File: rtl/add_three_arb.sv
// Arbitrates NREQ requesters onto one three-operand adder with a one-entry result stage.
// Define ADD_THREE_ARB_RR_EN for round-robin; otherwise lowest index wins.
module add_three_arb
    import add_three_arb_pkg::*;
#(
    parameter int BW   = DEF_BW,
    parameter int NREQ = DEF_NREQ
) (
    input  logic             clk,
    input  logic             rst,
    add_three_arb_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    arb_state_e     state;
    logic           can_accept;
    logic           any_valid;
    logic           grant;
    logic [IDW-1:0] win;
    logic [BW:0]    core_sum;
    logic           core_ovf;
    logic [BW:0]    sum_q;
    logic [IDW-1:0] id_q;
    logic           ovf_q;

`ifdef ADD_THREE_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // First pass covers indices at/above the pointer, second pass wraps below it.
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && bus.req_valid[i] && (IDW'(i) >= ptr)) begin
                any_valid = 1'b1;
                win       = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && bus.req_valid[i]) begin
                any_valid = 1'b1;
                win       = IDW'(i);
            end
        end
    end
`else
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                any_valid = 1'b1;
                win       = IDW'(i);
            end
        end
    end
`endif

    assign can_accept    = (state == EMPTY) || bus.res_ready;
    assign grant         = can_accept && any_valid && !rst;
    assign bus.req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

    add_three_core #(.BW(BW)) u_core (
        .a   (bus.req_a[win]),
        .b   (bus.req_b[win]),
        .c   (bus.req_c[win]),
        .sum (core_sum),
        .ovf (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            sum_q <= '0;
            id_q  <= '0;
            ovf_q <= 1'b0;
`ifdef ADD_THREE_ARB_RR_EN
            ptr   <= '0;
`endif
        end else if (grant) begin
            state <= FULL;
            sum_q <= core_sum;
            id_q  <= win;
            ovf_q <= core_ovf;
`ifdef ADD_THREE_ARB_RR_EN
            ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end else if ((state == FULL) && bus.res_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_id    = id_q;
    assign bus.res_ovf   = ovf_q;
endmodule
